prim_onehot_dec_pipe: RTL and testbench
=======================================

// Module: prim_onehot_dec_pipe
//
// PURPOSE
//  Streaming one-hot -> binary index decoder; inverse of the one-hot encoder primitive.
//  Accepts one-hot vectors over valid/ready, returns the set-bit index two cycles later.
//  Flags vectors that are not exactly one-hot and keeps a saturating error count.
//  Sits on select/grant return paths (arbiter grants, mux selects) ahead of binary-indexed logic.
//
// PARAMETERS
//  OneHotWidth  32  width of the one-hot input vector; must be >= 1
//  ErrCntWidth  8   width of the saturating error counter
//  (localparam) OutputWidth = (OneHotWidth > 1) ? $clog2(OneHotWidth) : 1
//
// PORTS
//  clk_i          in   1            clock; all logic on rising edge
//  rst_i          in   1            reset, synchronous, active-high
//  in_valid_i     in   1            input vector valid
//  in_ready_o     out  1            decoder can accept a vector this cycle
//  in_i           in   OneHotWidth  one-hot input vector
//  out_valid_o    out  1            decoded result valid
//  out_ready_i    in   1            downstream accepts result
//  out_o          out  OutputWidth  decoded index
//  out_err_o      out  1            input was not exactly one-hot (qualified by out_valid_o)
//  err_cnt_clr_i  in   1            clear error counter
//  err_cnt_o      out  ErrCntWidth  saturating count of erroneous results delivered
//
// BEHAVIOUR
//  - Reset: all valid flags 0, all data registers 0; out_valid_o=0, out_o=0, out_err_o=0,
//    err_cnt_o=0. Synchronous reset mid-stream discards every in-flight vector, no output.
//  - Two registered stages S1, S2. Transfer = valid & ready on a port.
//    S1 captures in_i raw on input transfer. S2 captures the decode of S1 when S1 advances.
//  - Latency: input transfer in cycle N -> out_valid_o high in cycle N+2 (no backpressure).
//  - Throughput 1 vector/cycle when out_ready_i held high.
//  - Ready chain (combinational, no bubble):
//      s2_ready   = !out_valid_o | out_ready_i
//      in_ready_o = !s1_valid    | s2_ready
//    in_ready_o does not depend on in_valid_i.
//  - Stall: while out_valid_o & !out_ready_i, out_o/out_err_o/out_valid_o stay stable;
//    S1 holds its content; at most 2 vectors buffered; no vector is dropped or duplicated.
//  - Decode rules (computed from S1 contents):
//      exactly one bit k set -> out_o=k, out_err_o=0
//      no bit set            -> out_o=0, out_err_o=1
//      >1 bits set           -> out_o=index of lowest set bit, out_err_o=1
//  - Error counter: increments by 1 on each output transfer with out_err_o=1;
//    saturates at 2^ErrCntWidth-1 (no wrap). err_cnt_clr_i sets it to 0 next cycle and
//    takes priority over a simultaneous increment (result 0, that error is not counted).
//  - OneHotWidth=1: out_o always 0; err only on all-zero input.
//  - No X propagation: S1/S2 data registers load only on transfer.
//
// STRUCTURE
//  - Package prim_onehot_dec_pkg: function lowest_set_idx (vector -> index),
//    function not_onehot (vector -> 1 if popcount != 1); both parameterised via width args.
//  - Sub-module prim_onehot_dec_stage: one valid/ready register slice
//    (Width param, data_i/valid_i/ready_o -> data_o/valid_o/ready_i), instantiated for S1
//    (Width=OneHotWidth) and S2 (Width=OutputWidth+1). Decode logic sits between them.
//  - Error counter lives in top level.
//
// TESTING
//  1. Single vector in_i=32'h0000_0100, out_ready_i=1 -> 2 cycles later out_o=8, out_err_o=0.
//  2. Back-to-back walking one 1<<0..1<<31, out_ready_i=1 -> out_o=0..31 in order,
//     one per cycle, in_ready_o never low.
//  3. in_i=0 then in_i=32'h0000_0014 -> out_o=0,err=1 then out_o=2,err=1; err_cnt_o=2.
//  4. out_ready_i=0 for 5 cycles with stream offered -> exactly 2 accepted, in_ready_o=0,
//     outputs stable; release -> remaining results in order, none lost.
//  5. ErrCntWidth=2, drive 5 all-zero vectors -> err_cnt_o saturates at 3;
//     err_cnt_clr_i coincident with an error transfer -> err_cnt_o=0.
//  6. Assert rst_i with 2 vectors in flight -> out_valid_o=0 next cycle, nothing emitted,
//     err_cnt_o=0, in_ready_o=1 after reset release.

Source files
------------

// File: rtl/prim_onehot_dec_pkg.sv
// Shared helpers for the one-hot -> binary decoder.
package prim_onehot_dec_pkg;

  // Upper bound on the one-hot vector width the helpers can take.
  localparam int MaxWidth = 1024;
  localparam int IdxW     = $clog2(MaxWidth);

  typedef logic [MaxWidth-1:0] vec_t;
  typedef logic [IdxW-1:0]     idx_t;

  // Index of the lowest set bit among vec[width-1:0]; 0 when no bit is set.
  function automatic idx_t lowest_set_idx(input vec_t vec, input int width);
    idx_t idx;
    idx = '0;
    for (int i = MaxWidth - 1; i >= 0; i--) begin
      if (i < width && vec[i]) idx = idx_t'(i);
    end
    return idx;
  endfunction

  // 1 when vec[width-1:0] does not have exactly one bit set.
  function automatic logic not_onehot(input vec_t vec, input int width);
    logic [1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i < width && vec[i] && cnt != 2'd2) cnt = cnt + 2'd1;
    end
    return (cnt != 2'd1);
  endfunction

endpackage

// File: rtl/prim_onehot_dec_stage.sv
// One valid/ready register slice. Full throughput: it can take a new item
// in the same cycle its current item leaves.
module prim_onehot_dec_stage #(
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Valid flag follows the input whenever the slot is free or draining.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
    end
  end

  // Data only loads on an actual transfer so idle inputs never leak in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (valid_i && ready_o) begin
      data_q <= data_i;
    end
  end

endmodule

// File: rtl/prim_onehot_dec_pipe.sv
// Streaming one-hot -> binary index decoder, two register stages.
// S1 holds the raw vector, S2 holds {err, index}. Non-one-hot inputs are
// flagged and counted in a saturating error counter.
module prim_onehot_dec_pipe
  import prim_onehot_dec_pkg::*;
#(
  parameter int OneHotWidth = 32,
  parameter int ErrCntWidth = 8,
  localparam int OutputWidth = (OneHotWidth > 1) ? $clog2(OneHotWidth) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [OneHotWidth-1:0] in_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OutputWidth-1:0] out_o,
  output logic                   out_err_o,
  input  logic                   err_cnt_clr_i,
  output logic [ErrCntWidth-1:0] err_cnt_o
);

  // OneHotWidth must lie in 1..MaxWidth for the package helpers to cover it.

  logic                   s1_valid, s2_ready;
  logic [OneHotWidth-1:0] s1_data;
  logic [OutputWidth:0]   s2_data;
  logic [OutputWidth:0]   dec_data;
  vec_t                   s1_vec;
  idx_t                   idx_full;

  prim_onehot_dec_stage #(.Width(OneHotWidth)) u_s1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (in_valid_i),
    .ready_o (in_ready_o),
    .data_i  (in_i),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_data)
  );

  // Decode S1 contents: lowest set bit index plus a not-one-hot flag.
  always_comb begin
    s1_vec                  = '0;
    s1_vec[OneHotWidth-1:0] = s1_data;
    idx_full                = lowest_set_idx(s1_vec, OneHotWidth);
    dec_data                = {not_onehot(s1_vec, OneHotWidth), idx_full[OutputWidth-1:0]};
  end

  prim_onehot_dec_stage #(.Width(OutputWidth + 1)) u_s2 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (dec_data),
    .valid_o (out_valid_o),
    .ready_i (out_ready_i),
    .data_o  (s2_data)
  );

  assign out_o     = s2_data[OutputWidth-1:0];
  assign out_err_o = s2_data[OutputWidth];

  logic [ErrCntWidth-1:0] err_cnt_d, err_cnt_q;

  // Count delivered errors; clear wins over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (out_valid_o && out_ready_i && out_err_o && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_prim_onehot_dec_pipe.sv
// Scoreboard bench for prim_onehot_dec_pipe: stimulus pushes expectations,
// a monitor pops and compares on every output transfer.
module tb_prim_onehot_dec_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_vec = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_idx;
  logic        out_err;
  logic        clr = 1'b0;
  logic [7:0]  err_cnt;

  // Second instance: narrow vector, 2-bit counter for saturation checks.
  logic       d2_in_valid = 1'b0;
  logic       d2_in_ready;
  logic [3:0] d2_in = '0;
  logic       d2_out_valid;
  logic [1:0] d2_out;
  logic       d2_err;
  logic       d2_clr = 1'b0;
  logic [1:0] d2_cnt;

  always #5 clk = ~clk;

  prim_onehot_dec_pipe #(.OneHotWidth(32), .ErrCntWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_i(in_vec), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_o(out_idx), .out_err_o(out_err), .err_cnt_clr_i(clr), .err_cnt_o(err_cnt)
  );

  prim_onehot_dec_pipe #(.OneHotWidth(4), .ErrCntWidth(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(d2_in_valid), .in_ready_o(d2_in_ready),
    .in_i(d2_in), .out_valid_o(d2_out_valid), .out_ready_i(1'b1),
    .out_o(d2_out), .out_err_o(d2_err), .err_cnt_clr_i(d2_clr), .err_cnt_o(d2_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int acc_n = 0;
  bit waited = 0;
  logic [5:0] exp_q[$];   // {err, idx}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one vector; record expectation at the cycle it is accepted.
  task automatic send(input logic [31:0] v, input logic [4:0] idx, input logic err);
    in_valid = 1'b1;
    in_vec   = v;
    #1;
    for (int t = 0; t < 100; t++) begin
      if (in_ready) begin
        exp_q.push_back({err, idx});
        acc_n++;
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      waited = 1;
      @(negedge clk);
      #1;
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 0);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare each output transfer against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {58'd0, out_err, out_idx}, 64'h3f);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          chk("out_idx", out_idx, e[4:0]);
          chk("out_err", out_err, e[5]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_o", out_idx, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // 1: single vector, latency 2
    send(32'h0000_0100, 5'd8, 1'b0);
    #1;
    chk("lat_not_yet", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_valid", out_valid, 1);
    drain();

    // 2: walking one, back-to-back
    @(negedge clk);
    waited = 0;
    for (int i = 0; i < 32; i++) send(32'd1 << i, 5'(i), 1'b0);
    chk("walk_in_ready_never_low", waited, 0);
    drain();

    // 3: zero and multi-hot vectors
    chk("cnt_before_err", err_cnt, 0);
    @(negedge clk);
    send(32'h0, 5'd0, 1'b1);
    send(32'h0000_0014, 5'd2, 1'b1);
    drain();
    chk("err_cnt_two", err_cnt, 2);

    // 4: backpressure for 5 cycles
    @(negedge clk);
    out_ready = 1'b0;
    begin
      int base;
      base = acc_n;
      fork
        begin
          send(32'h0000_0008, 5'd3, 1'b0);
          send(32'h0000_0020, 5'd5, 1'b0);
          send(32'h0000_0080, 5'd7, 1'b0);
          send(32'h0000_0200, 5'd9, 1'b0);
        end
        begin
          repeat (3) @(negedge clk);
          #2;
          chk("stall_out_o_c3", out_idx, 3);
          repeat (2) @(negedge clk);
          #2;
          chk("stall_accepted", 64'(acc_n - base), 2);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_o_c5", out_idx, 3);
          @(negedge clk);
          out_ready = 1'b1;
        end
      join
    end
    drain();

    // 5: saturation and clear priority on the narrow instance
    d2_in_valid = 1'b1;
    d2_in = 4'b0000;
    repeat (5) @(negedge clk);
    d2_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sat_cnt", d2_cnt, 3);
    @(negedge clk);
    d2_in_valid = 1'b1;
    d2_in = 4'b1000;
    @(negedge clk);
    d2_in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("d2_valid", d2_out_valid, 1);
    chk("d2_idx3", d2_out, 3);
    chk("d2_err0", d2_err, 0);
    @(negedge clk);
    d2_in_valid = 1'b1;
    d2_in = 4'b0110;
    @(negedge clk);
    d2_in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("d2_multi_idx", d2_out, 1);
    chk("d2_multi_err", d2_err, 1);
    d2_clr = 1'b1;
    @(negedge clk);
    d2_clr = 1'b0;
    #1;
    chk("clr_priority", d2_cnt, 0);

    // 6: reset with two vectors in flight
    out_ready = 1'b0;
    send(32'h0000_0001, 5'd0, 1'b0);
    send(32'h0000_0002, 5'd1, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("postrst_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("postrst_no_output", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
